// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition run controller.
package acq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    ERROR = 3'd4
  } state_e;

  // FrameLength field inside host config word 1
  localparam int FL_MSB = 12;
  localparam int FL_LSB = 0;
  localparam int FL_W   = FL_MSB - FL_LSB + 1;

  localparam int ARM_CYCLES_DEF = 16;
  localparam int STALL_W_DEF    = 16;

endpackage

// File: rtl/acq_watchdog.sv
// Word-gap watchdog: counts idle clocks while enabled, flags when it reaches all-ones.
module acq_watchdog
  import acq_pkg::*;
#(
  parameter int W = STALL_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                   cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/acq_ctrl.sv
// Acquisition run controller: arms the packer, counts frames, ends runs and
// traps FIFO overflow / word-stall errors.
module acq_ctrl
  import acq_pkg::*;
#(
  parameter int FRAMES_W   = 24,
  parameter int ARM_CYCLES = ARM_CYCLES_DEF,
  parameter int STALL_W    = STALL_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic [FRAMES_W-1:0] cfg_frames,
  input  logic [31:0]         cfg_reg1_in,
  input  logic [31:0]         cfg_reg2_in,
  input  logic                pkt_valid,
  input  logic [12:0]         pkt_sextet,
  input  logic                fifo_full,
  output logic                packer_rst,
  output logic [31:0]         packer_cfg1,
  output logic [31:0]         packer_cfg2,
  output logic                busy,
  output logic                run_done,
  output logic [FRAMES_W-1:0] frames_done,
  output logic                err_overflow,
  output logic                err_stall
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  // Reset asserts immediately, releases two clocks after rst_n rises
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  state_e              state_q, state_d;
  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic [31:0]         cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [FRAMES_W-1:0] fd_q, fd_d, fd_inc;
  logic                run_done_q, run_done_d;
  logic                ovf_q, ovf_d, stall_q, stall_d;

  logic start_ok, frame_end, run_hit, active, wd_expired;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign start_ok  = cmd_start && !cmd_stop && (cfg_reg1_in[FL_MSB:FL_LSB] != '0);
  assign frame_end = pkt_valid && (pkt_sextet == cfg1_q[FL_MSB:FL_LSB]);
  assign fd_inc    = (&fd_q) ? fd_q : fd_q + 1'b1;
  assign run_hit   = (frames_q != '0) && (fd_inc == frames_q);

  acq_watchdog #(.W(STALL_W)) u_wd (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .clear   (pkt_valid || !active),
    .enable  (active),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    cfg1_d     = cfg1_q;
    cfg2_d     = cfg2_q;
    frames_d   = frames_q;
    fd_d       = fd_q;
    ovf_d      = ovf_q;
    stall_d    = stall_q;
    run_done_d = 1'b0;
    case (state_q)
      IDLE, ERROR: begin
        if (cmd_stop) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d   = ARM;
          arm_cnt_d = '0;
          cfg1_d    = cfg_reg1_in;
          cfg2_d    = cfg_reg2_in;
          frames_d  = cfg_frames;
          fd_d      = '0;
          ovf_d     = 1'b0;
          stall_d   = 1'b0;
        end
      end
      ARM: begin
        if (cmd_stop)                  state_d = IDLE;
        else if (arm_cnt_q == ARM_LAST) state_d = RUN;
        else                           arm_cnt_d = arm_cnt_q + 1'b1;
      end
      RUN: begin
        // Overflow wins over everything, and its coincident frame is dropped
        if (fifo_full) begin
          state_d = ERROR;
          ovf_d   = 1'b1;
        end else if (wd_expired && !pkt_valid) begin
          state_d = ERROR;
          stall_d = 1'b1;
        end else if (frame_end) begin
          fd_d = fd_inc;
          if (run_hit) begin
            state_d    = IDLE;
            run_done_d = 1'b1;
          end else if (cmd_stop) begin
            state_d = DRAIN;
          end
        end else if (cmd_stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_full) begin
          state_d = ERROR;
          ovf_d   = 1'b1;
        end else if (wd_expired && !pkt_valid) begin
          state_d = ERROR;
          stall_d = 1'b1;
        end else if (frame_end) begin
          fd_d       = fd_inc;
          state_d    = IDLE;
          run_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      arm_cnt_q  <= '0;
      cfg1_q     <= '0;
      cfg2_q     <= '0;
      frames_q   <= '0;
      fd_q       <= '0;
      run_done_q <= 1'b0;
      ovf_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      cfg1_q     <= cfg1_d;
      cfg2_q     <= cfg2_d;
      frames_q   <= frames_d;
      fd_q       <= fd_d;
      run_done_q <= run_done_d;
      ovf_q      <= ovf_d;
      stall_q    <= stall_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign packer_rst   = !active;
  assign packer_cfg1  = cfg1_q;
  assign packer_cfg2  = cfg2_q;
  assign run_done     = run_done_q;
  assign frames_done  = fd_q;
  assign err_overflow = ovf_q;
  assign err_stall    = stall_q;

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl: normal run, drain, overflow, stall and reset cases.
module tb_acq_ctrl;
  import acq_pkg::*;

  localparam int FW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_start = 1'b0, cmd_stop = 1'b0;
  logic [FW-1:0] cfg_frames = '0;
  logic [31:0]   cfg_reg1_in = '0, cfg_reg2_in = '0;
  logic          pkt_valid = 1'b0;
  logic [12:0]   pkt_sextet = '0;
  logic          fifo_full = 1'b0;
  logic          packer_rst, busy, run_done, err_overflow, err_stall;
  logic [31:0]   packer_cfg1, packer_cfg2;
  logic [FW-1:0] frames_done;

  int n_cmp = 0;
  int n_err = 0;

  acq_ctrl #(.FRAMES_W(FW), .ARM_CYCLES(16), .STALL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_frames(cfg_frames), .cfg_reg1_in(cfg_reg1_in), .cfg_reg2_in(cfg_reg2_in),
    .pkt_valid(pkt_valid), .pkt_sextet(pkt_sextet), .fifo_full(fifo_full),
    .packer_rst(packer_rst), .packer_cfg1(packer_cfg1), .packer_cfg2(packer_cfg2),
    .busy(busy), .run_done(run_done), .frames_done(frames_done),
    .err_overflow(err_overflow), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] r1, input logic [31:0] r2, input logic [FW-1:0] fr);
    cfg_reg1_in = r1;
    cfg_reg2_in = r2;
    cfg_frames  = fr;
    cmd_start   = 1'b1;
    tick();
    cmd_start   = 1'b0;
  endtask

  task automatic pkt(input logic [12:0] sx, input logic full);
    pkt_valid  = 1'b1;
    pkt_sextet = sx;
    fifo_full  = full;
    tick();
    pkt_valid  = 1'b0;
    fifo_full  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_prst"}, 32'(packer_rst), 32'd1);
    chk({tag, "_cfg1"}, packer_cfg1, 32'd0);
    chk({tag, "_cfg2"}, packer_cfg2, 32'd0);
    chk({tag, "_fd"}, 32'(frames_done), 32'd0);
    chk({tag, "_rdone"}, 32'(run_done), 32'd0);
    chk({tag, "_ovf"}, 32'(err_overflow), 32'd0);
    chk({tag, "_stall"}, 32'(err_stall), 32'd0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #4 chk_reset_vals("rst");
    tick(2);
    #2 rst_n = 1'b1;
    tick(3);
    chk_reset_vals("post_rst");

    // start together with stop: stop wins
    cfg_reg1_in = 32'd3; cmd_start = 1'b1; cmd_stop = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    chk("start_stop_busy", 32'(busy), 32'd0);
    chk("start_stop_cfg1", packer_cfg1, 32'd0);

    // FrameLength zero: start ignored
    start_run(32'h1000_0000, 32'h55, 24'd1);
    chk("fl0_busy", 32'(busy), 32'd0);
    chk("fl0_cfg1", packer_cfg1, 32'd0);

    // Normal run: FL=3, two frames
    start_run(32'hABCD_0003, 32'h1234_5678, 24'd2);
    cfg_reg1_in = 32'd5;
    cfg_reg2_in = 32'd0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_cfg1", packer_cfg1, 32'hABCD_0003);
    chk("arm_cfg2", packer_cfg2, 32'h1234_5678);
    tick(15);
    chk("arm15_prst", 32'(packer_rst), 32'd1);
    chk("arm15_cfg1", packer_cfg1, 32'hABCD_0003);
    tick();
    chk("arm16_prst", 32'(packer_rst), 32'd0);
    pkt(13'd3, 1'b0);
    chk("run_fd1", 32'(frames_done), 32'd1);
    chk("run_rdone0", 32'(run_done), 32'd0);
    pkt(13'd2, 1'b0);
    chk("run_nomatch_fd", 32'(frames_done), 32'd1);
    pkt(13'd3, 1'b0);
    chk("end_fd2", 32'(frames_done), 32'd2);
    chk("end_rdone", 32'(run_done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_prst", 32'(packer_rst), 32'd1);
    tick();
    chk("end_rdone_pulse", 32'(run_done), 32'd0);
    pkt(13'd3, 1'b0);
    chk("idle_pkt_ignored", 32'(frames_done), 32'd2);

    // Stop with drain, continuous mode
    start_run(32'h0000_0007, 32'h0, 24'd0);
    chk("drain_fd_clr", 32'(frames_done), 32'd0);
    tick(16);
    chk("drain_in_run", 32'(dut.state_q), 32'(RUN));
    pkt(13'd7, 1'b0);
    chk("drain_fd1", 32'(frames_done), 32'd1);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("drain_state", 32'(dut.state_q), 32'(DRAIN));
    chk("drain_prst", 32'(packer_rst), 32'd0);
    pkt(13'd1, 1'b0);
    chk("drain_hold", 32'(dut.state_q), 32'(DRAIN));
    pkt(13'd7, 1'b0);
    chk("drain_fd2", 32'(frames_done), 32'd2);
    chk("drain_rdone", 32'(run_done), 32'd1);
    chk("drain_prst_end", 32'(packer_rst), 32'd1);
    chk("drain_busy_end", 32'(busy), 32'd0);

    // Overflow coinciding with a frame end
    start_run(32'h0000_0007, 32'h0, 24'd5);
    tick(16);
    pkt(13'd7, 1'b0);
    chk("ovf_fd1", 32'(frames_done), 32'd1);
    pkt(13'd7, 1'b1);
    chk("ovf_state", 32'(dut.state_q), 32'(ERROR));
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_fd_kept", 32'(frames_done), 32'd1);
    chk("ovf_prst", 32'(packer_rst), 32'd1);
    chk("ovf_rdone", 32'(run_done), 32'd0);
    tick(2);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);
    start_run(32'h0000_0009, 32'h0, 24'd0);
    chk("ovf_clr", 32'(err_overflow), 32'd0);
    chk("ovf_restart_arm", 32'(dut.state_q), 32'(ARM));
    chk("ovf_restart_cfg1", packer_cfg1, 32'h0000_0009);

    // Stop in ARM: back to idle, no run_done
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("armstop_busy", 32'(busy), 32'd0);
    chk("armstop_rdone", 32'(run_done), 32'd0);
    tick();
    chk("armstop_rdone2", 32'(run_done), 32'd0);

    // Stall: STALL_W=4, counter reaches 15 after 15 idle RUN clocks, error on the next
    start_run(32'h0000_0004, 32'h0, 24'd0);
    tick(16);
    chk("stall_in_run", 32'(dut.state_q), 32'(RUN));
    tick(15);
    chk("stall_not_yet", 32'(err_stall), 32'd0);
    tick();
    chk("stall_flag", 32'(err_stall), 32'd1);
    chk("stall_state", 32'(dut.state_q), 32'(ERROR));
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("stall_stop_idle", 32'(busy), 32'd0);
    chk("stall_sticky", 32'(err_stall), 32'd1);

    // Reset mid-run
    start_run(32'hFFFF_0006, 32'hCAFE_F00D, 24'd0);
    chk("mid_stall_clr", 32'(err_stall), 32'd0);
    tick(16);
    pkt(13'd6, 1'b0);
    chk("mid_fd1", 32'(frames_done), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    tick(2);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_rel_rdone", 32'(run_done), 32'd0);
    tick(2);
    chk_reset_vals("mid_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
